bus_initiator: RTL and testbench
================================

// Module: bus_initiator
// PURPOSE
//  Single-outstanding bus master: drives the shared register bus (bus_in) and collects the wire-ORed
//  slave responses (bus_out). Converts a valid/ready command stream (host bridge, sequencer) into one-cycle
//  read/write strobes and returns read data or an error on a valid/ready response stream.
//  Masked-write slaves are reached via cmd_wr_data[31:16] = write mask, [15:0] = data.
// PARAMETERS
//  TIMEOUT   255  bus cycles to wait for an ack after the strobe before flagging an error (>=2)
//  TCW       $clog2(TIMEOUT+1)  timeout counter width (derived localparam, not overridden)
// PORTS
//  bus_clk      in   1               bus clock; also drives the clock field of bus_in
//  bus_reset_l  in   1               asynchronous active-low reset; also drives the reset field of bus_in
//  cmd_valid    in   1               command present
//  cmd_ready    out  1               block accepts command (IDLE only)
//  cmd_we       in   1               1 = write, 0 = read
//  cmd_addr     in   BUS_ADDR_WIDTH  byte address; bits [1:0] forced to 0 on the bus
//  cmd_wr_data  in   BUS_DATA_WIDTH  write data (ignored for reads)
//  rsp_valid    out  1               response present
//  rsp_ready    in   1               consumer takes response
//  rsp_rd_data  out  BUS_DATA_WIDTH  read data; 0 for writes and errors
//  rsp_err      out  1               1 = ack not received (timeout) or both acks seen at once
//  busy         out  1               state != IDLE
//  bus_in       out  BUS_IN_WIDTH    packed bus to slaves, per bus_params.v field layout
//  bus_out      in   BUS_OUT_WIDTH   wire-ORed slave returns (rd data, rd ack, wr ack, irq)
// BEHAVIOUR
//  Reset (async assert, sync deassert by bus_clk domain): state IDLE, cmd_ready=1, rsp_valid=0,
//   rsp_rd_data=0, rsp_err=0, bus re/we=0, bus addr/wr_data=0, timeout count=0.
//  FSM: IDLE -(cmd_valid&&cmd_ready)-> STROBE -> WAIT -(ack|timeout)-> RESP -(rsp_ready)-> IDLE.
//  IDLE: cmd_ready=1; on accept latch we/addr/wr_data into bus-side registers.
//  STROBE: exactly one cycle of re (read) or we (write); addr/wr_data valid this cycle and held until RESP.
//  WAIT: re=we=0; slaves register ack, so earliest ack is the cycle after STROBE.
//   Read: rd ack -> capture bus_out rd-data field that same cycle, rsp_err=0.
//   Write: wr ack -> rsp_rd_data=0, rsp_err=0.
//   Wrong-type ack (wr ack on read, rd ack on write) or both acks same cycle -> rsp_err=1, rd_data=0.
//  RESP: rsp_valid=1, outputs stable until rsp_ready; exit clears rsp_valid same edge.
//  Min latency: accept edge -> rsp_valid high 3 edges later (STROBE, WAIT, RESP).
//  Acks arriving in IDLE/STROBE/RESP are ignored (no state effect); irq field not used by this block.
//  cmd_ready is 0 outside IDLE; at most one transaction outstanding; no back-to-back strobes.
//  Reset mid-transaction: FSM to IDLE, strobes drop immediately (async), pending response discarded.
// CONFIGURATION
//  BUS_INITIATOR_TIMEOUT_EN defined: WAIT counts cycles; when count reaches TIMEOUT without ack ->
//   RESP with rsp_err=1, rsp_rd_data=0; counter cleared on entry to WAIT.
//  Not defined: no counter; WAIT holds until an ack arrives (hangs on unmapped address); rsp_err
//   only from wrong-type/double ack.
// STRUCTURE
//  Field offsets/widths (BUS_*_WIDTH, BUS_FIELD_*, BUS_RD_DATA_START/END) from the shared bus_params.v
//   include; the FSM state encoding (IDLE/STROBE/WAIT/RESP) belongs in the same shared parameter set
//   for reuse by bus monitors.
//  Single flat module; the bus_in packing is an assign block, no sub-module needed.
// TESTING
//  Bench: bus_initiator + bus_mask_reg at ADDR 'h10 (IZ 'h00A5) + plain slave model; TIMEOUT=16.
//  1 Read 'h10 after reset -> one-cycle re, rsp_valid 3 edges after accept, rd_data='h00A5, err=0.
//  2 Write 'h10 data 'h00F0_0FFF then read -> single we pulse, wr_pulse once, readback 'h00F5.
//  3 Read unmapped 'h200 with _EN -> rsp_err=1, rd_data=0 after 16 WAIT cycles; without _EN busy stays 1.
//  4 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, cmd_ready=0, no new strobe; release -> IDLE.
//  5 Assert bus_reset_l=0 during WAIT -> re/we/rsp_valid 0 immediately, cmd_ready=1 after release.
//  6 Slave model returns wr ack to a read -> rsp_err=1, rd_data=0; late ack in IDLE ignored.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// bus_initiator_pkg: shared register-bus field layout and initiator FSM state encoding
package bus_initiator_pkg;
  localparam int BUS_ADDR_WIDTH    = 32;
  localparam int BUS_DATA_WIDTH    = 32;
  localparam int BUS_FIELD_CLK     = 0;
  localparam int BUS_FIELD_RESET_L = 1;
  localparam int BUS_FIELD_RE      = 2;
  localparam int BUS_FIELD_WE      = 3;
  localparam int BUS_FIELD_ADDR    = 4;
  localparam int BUS_FIELD_WR_DATA = BUS_FIELD_ADDR + BUS_ADDR_WIDTH;
  localparam int BUS_IN_WIDTH      = BUS_FIELD_WR_DATA + BUS_DATA_WIDTH;
  localparam int BUS_RD_DATA_START = 0;
  localparam int BUS_RD_DATA_END   = BUS_DATA_WIDTH - 1;
  localparam int BUS_FIELD_RD_ACK  = BUS_DATA_WIDTH;
  localparam int BUS_FIELD_WR_ACK  = BUS_DATA_WIDTH + 1;
  localparam int BUS_FIELD_IRQ     = BUS_DATA_WIDTH + 2;
  localparam int BUS_OUT_WIDTH     = BUS_DATA_WIDTH + 3;
  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, WAIT = 2'd2, RESP = 2'd3} bus_state_e;
endpackage

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding register-bus master (cmd stream -> one-cycle strobe -> rsp stream)
//  Ports: bus_clk/bus_reset_l (async active-low, also forwarded on bus_in); cmd_valid/cmd_ready/cmd_we/
//  cmd_addr/cmd_wr_data command stream; rsp_valid/rsp_ready/rsp_rd_data/rsp_err response stream;
//  busy (not IDLE); bus_in packed bus to slaves; bus_out wire-ORed slave returns.
//  Option: define BUS_INITIATOR_TIMEOUT_EN to end WAIT with rsp_err after TIMEOUT cycles without ack.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                      bus_clk,
  input  logic                      bus_reset_l,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_wr_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [BUS_DATA_WIDTH-1:0] rsp_rd_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [BUS_IN_WIDTH-1:0]   bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]  bus_out
);
  bus_state_e state, nxt;
  logic we_r;
  logic [BUS_ADDR_WIDTH-1:0] addr_r;
  logic [BUS_DATA_WIDTH-1:0] wdata_r;
  logic rd_ack, wr_ack, any_ack, good_rd, good_wr, timed_out, done, unused_irq;
  assign rd_ack = bus_out[BUS_FIELD_RD_ACK];
  assign wr_ack = bus_out[BUS_FIELD_WR_ACK];
  assign unused_irq = bus_out[BUS_FIELD_IRQ];
  assign any_ack = rd_ack | wr_ack;
  assign good_rd = rd_ack && !wr_ack && !we_r;
  assign good_wr = wr_ack && !rd_ack && we_r;
  assign done = state == WAIT && (any_ack || timed_out);
`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] cnt;
  assign timed_out = cnt == TCW'(TIMEOUT - 1);
  always_ff @(posedge bus_clk or negedge bus_reset_l)
    if (!bus_reset_l) cnt <= '0;
    else if (state == STROBE) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timed_out = 1'b0;
`endif
  always_ff @(posedge bus_clk or negedge bus_reset_l)
    if (!bus_reset_l) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cmd_valid ? STROBE : IDLE;
      STROBE:  nxt = WAIT;
      WAIT:    nxt = done ? RESP : WAIT;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge bus_clk or negedge bus_reset_l)
    if (!bus_reset_l) begin
      we_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
      rsp_rd_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        we_r <= cmd_we;
        addr_r <= {cmd_addr[BUS_ADDR_WIDTH-1:2], 2'b00};
        wdata_r <= cmd_wr_data;
      end
      if (done) begin
        rsp_err <= !good_rd && !good_wr;
        rsp_rd_data <= good_rd ? bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START] : '0;
      end
    end
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  // strobes decode straight from the state register so an async reset removes them at once
  assign bus_in[BUS_FIELD_CLK] = bus_clk;
  assign bus_in[BUS_FIELD_RESET_L] = bus_reset_l;
  assign bus_in[BUS_FIELD_RE] = state == STROBE && !we_r;
  assign bus_in[BUS_FIELD_WE] = state == STROBE && we_r;
  assign bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH] = addr_r;
  assign bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH] = wdata_r;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: randomized self-checking bench with mask-register and plain slave models
module tb_bus_initiator;
  import bus_initiator_pkg::*;
  logic bus_clk = 0, bus_reset_l = 0;
  logic cmd_valid = 0, cmd_we = 0, rsp_ready = 0;
  logic [31:0] cmd_addr = 0, cmd_wr_data = 0;
  logic cmd_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rd_data;
  logic [BUS_IN_WIDTH-1:0] bus_in;
  logic [BUS_OUT_WIDTH-1:0] bus_out;
  int errors = 0, checks = 0;
  int re_cnt = 0, we_cnt = 0, b2b = 0, wr_pulses = 0;
  logic prev_strobe = 0;
  logic [1:0] mode = 0;
  logic inj_rd = 0, inj_wr = 0;
  logic [31:0] inj_data = 0;
  logic s_rd_ack = 0, s_wr_ack = 0;
  logic [31:0] s_rd_data = 0, preg = 0;
  logic [15:0] mreg = 16'h00A5;
  logic [15:0] m_mask = 16'h00A5;
  logic [31:0] m_plain = 0;
  bus_initiator #(.TIMEOUT(16)) dut (
    .bus_clk(bus_clk), .bus_reset_l(bus_reset_l), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wr_data(cmd_wr_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err), .busy(busy),
    .bus_in(bus_in), .bus_out(bus_out));
  always #5 bus_clk = ~bus_clk;
  wire s_re = bus_in[BUS_FIELD_RE];
  wire s_we = bus_in[BUS_FIELD_WE];
  wire [31:0] s_addr = bus_in[BUS_FIELD_ADDR +: 32];
  wire [31:0] s_wd = bus_in[BUS_FIELD_WR_DATA +: 32];
  always_comb begin
    bus_out = '0;
    bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = s_rd_data | inj_data;
    bus_out[BUS_FIELD_RD_ACK] = s_rd_ack | inj_rd;
    bus_out[BUS_FIELD_WR_ACK] = s_wr_ack | inj_wr;
  end
  always @(posedge bus_clk) begin
    s_rd_ack <= 0;
    s_wr_ack <= 0;
    s_rd_data <= 0;
    if (s_re && (s_addr == 32'h10 || s_addr == 32'h20)) begin
      if (mode != 1) begin
        s_rd_ack <= 1;
        s_rd_data <= s_addr == 32'h10 ? {16'h0, mreg} : preg;
      end
      if (mode != 0) s_wr_ack <= 1;
    end
    if (s_we && s_addr == 32'h10) begin
      for (int i = 0; i < 16; i++) if (s_wd[16+i]) mreg[i] <= s_wd[i];
      wr_pulses <= wr_pulses + 1;
      s_wr_ack <= 1;
    end
    if (s_we && s_addr == 32'h20) begin
      preg <= s_wd;
      s_wr_ack <= 1;
    end
  end
  always @(posedge bus_clk) begin
    if (s_re) re_cnt++;
    if (s_we) we_cnt++;
    if ((s_re | s_we) && prev_strobe) b2b++;
    prev_strobe = s_re | s_we;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold,
                     output logic [31:0] rd, output logic e, output int lat);
    int s0;
    logic stable;
    @(negedge bus_clk);
    cmd_we = w; cmd_addr = a; cmd_wr_data = d; cmd_valid = 1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge bus_clk); #1 cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge bus_clk); #1 lat++;
    end
    rd = rsp_rd_data;
    e = rsp_err;
    stable = 1;
    s0 = re_cnt + we_cnt;
    repeat (hold) begin
      @(posedge bus_clk); #1
      if (!rsp_valid || rsp_rd_data !== rd || rsp_err !== e || cmd_ready) stable = 0;
    end
    if (hold > 0) begin
      chk("hold_stable", stable, 1);
      chk("hold_no_strobe", re_cnt + we_cnt - s0, 0);
    end
    if (rsp_valid) begin
      @(negedge bus_clk) rsp_ready = 1;
      @(posedge bus_clk); #1 rsp_ready = 0;
      chk("resp_exit", {rsp_valid, busy}, 0);
    end
  endtask
  task automatic pulse_reset();
    bus_reset_l = 0;
    @(negedge bus_clk) bus_reset_l = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] rd, a, d, exp;
    logic e, w;
    int lat, r0, w0, p0;
    repeat (3) @(negedge bus_clk);
    chk("reset_outs", {cmd_ready, rsp_valid, busy, rsp_err, rsp_rd_data}, {3'b100, 1'b0, 32'h0});
    chk("reset_bus", bus_in[BUS_IN_WIDTH-1:BUS_FIELD_RE], 0);
    bus_reset_l = 1;
    @(negedge bus_clk);
    r0 = re_cnt;
    txn(0, 32'h10, 0, 0, rd, e, lat);
    chk("rd_iz_data", rd, 32'h00A5);
    chk("rd_iz_err", e, 0);
    chk("rd_iz_latency", lat, 3);
    chk("rd_one_re", re_cnt - r0, 1);
    w0 = we_cnt; p0 = wr_pulses;
    txn(1, 32'h10, 32'h00F0_0FFF, 0, rd, e, lat);
    m_mask = (m_mask & ~16'h00F0) | (16'h0FFF & 16'h00F0);
    chk("wr_rsp", {e, rd}, 0);
    chk("wr_latency", lat, 3);
    chk("wr_one_we", we_cnt - w0, 1);
    chk("wr_pulse_once", wr_pulses - p0, 1);
    txn(0, 32'h10, 0, 0, rd, e, lat);
    chk("readback", rd, {16'h0, m_mask});
    txn(0, 32'h13, 0, 0, rd, e, lat);
    chk("addr_low_forced", {e, rd}, {1'b0, 16'h0, m_mask});
    txn(0, 32'h200, 0, 0, rd, e, lat);
`ifdef BUS_INITIATOR_TIMEOUT_EN
    chk("timeout_rsp", {e, rd}, {1'b1, 32'h0});
    chk("timeout_latency", lat, 18);
`else
    chk("hang_busy", {busy, rsp_valid}, 2'b10);
    pulse_reset();
    #1 chk("hang_recover", cmd_ready, 1);
`endif
    txn(1, 32'h20, 32'hDEAD_BEEF, 0, rd, e, lat);
    m_plain = 32'hDEAD_BEEF;
    txn(0, 32'h20, 0, 10, rd, e, lat);
    chk("hold_rd", {e, rd}, {1'b0, m_plain});
    @(negedge bus_clk);
    cmd_we = 0; cmd_addr = 32'h10; cmd_valid = 1;
    @(posedge bus_clk); #1 cmd_valid = 0;
    chk("strobe_re_on", s_re, 1);
    bus_reset_l = 0;
    #1 chk("reset_strobe_drop", {s_re, s_we, busy}, 0);
    @(negedge bus_clk) bus_reset_l = 1;
    @(negedge bus_clk);
    cmd_we = 0; cmd_addr = 32'h200; cmd_valid = 1;
    @(posedge bus_clk); #1 cmd_valid = 0;
    @(posedge bus_clk); #2;
    chk("in_wait_busy", busy, 1);
    bus_reset_l = 0;
    #1 chk("reset_wait_drop", {s_re, s_we, rsp_valid, busy}, 0);
    @(negedge bus_clk) bus_reset_l = 1;
    @(posedge bus_clk); #1 chk("ready_after_reset", cmd_ready, 1);
    mode = 1;
    txn(0, 32'h10, 0, 0, rd, e, lat);
    chk("wrong_ack", {e, rd}, {1'b1, 32'h0});
    mode = 2;
    txn(0, 32'h20, 0, 0, rd, e, lat);
    chk("double_ack", {e, rd}, {1'b1, 32'h0});
    mode = 0;
    @(negedge bus_clk) begin inj_rd = 1; inj_wr = 1; inj_data = 32'h1234_5678; end
    @(negedge bus_clk) begin inj_rd = 0; inj_wr = 0; inj_data = 0; end
    @(posedge bus_clk); #1
    chk("late_ack_ignored", {busy, rsp_valid, cmd_ready, s_re, s_we}, 5'b00100);
    txn(0, 32'h10, 0, 0, rd, e, lat);
    chk("read_after_late_ack", {e, rd}, {1'b0, 16'h0, m_mask});
    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 1) ? 32'h10 : 32'h20) | 32'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      exp = (a[5:2] == 4'h4) ? {16'h0, m_mask} : m_plain;
      txn(w, a, d, $urandom_range(0, 2), rd, e, lat);
      chk("rand_rsp", {e, rd}, {1'b0, w ? 32'h0 : exp});
      chk("rand_latency", lat, 3);
      if (w && a[5:2] == 4'h4) m_mask = (m_mask & ~d[31:16]) | (d[15:0] & d[31:16]);
      if (w && a[5:2] == 4'h8) m_plain = d;
    end
    chk("no_back_to_back", b2b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
